// File: rtl/secure_switch_poller_if.sv
// AXI4-Lite read-channel bundle between the switch poller and the secure interconnect.
// Write channels do not exist here; the interconnect ties them off.
interface secure_switch_poller_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/secure_switch_poller.sv
// Autonomous AXI4-Lite read master that polls the secure switch register, keeps a
// shadow copy and raises a level interrupt when the switch state changes.
module secure_switch_poller #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 4,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] SW_REG_ADDR        = '0,
  parameter int unsigned                   POLL_PERIOD        = 100000
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  enable,
  input  logic                  irq_ack,
  input  logic                  err_clr,
  secure_switch_poller_if.master m_axi,
  output logic [1:0]            sw_state,
  output logic                  sw_valid,
  output logic [1:0]            change_mask,
  output logic                  irq,
  output logic                  bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam logic [23:0] PERIOD_LOAD = 24'(POLL_PERIOD - 1);

  logic [1:0]  state;
  logic [23:0] cnt;
  logic        arvalid_r;
  logic        rready_r;

  logic        rd_done;
  logic        rd_ok;
  logic        rd_bad;
  logic [1:0]  rd_val;
  logic [1:0]  rd_diff;
  logic        change;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_unused;

  // Only the two switch bits of the read word are meaningful.
  assign rdata_unused = m_axi.rdata;
  assign rd_val       = m_axi.rdata[1:0];

  assign m_axi.araddr  = SW_REG_ADDR;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_r;
  assign m_axi.rready  = rready_r;

  assign rd_done = (state == DATA) && m_axi.rvalid;
  assign rd_ok   = rd_done && (m_axi.rresp == 2'b00);
  assign rd_bad  = rd_done && (m_axi.rresp != 2'b00);
  assign rd_diff = rd_val ^ sw_state;
  assign change  = rd_ok && sw_valid && (rd_diff != 2'b00);

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state       <= IDLE;
      cnt         <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      sw_state    <= '0;
      sw_valid    <= 1'b0;
      change_mask <= '0;
      irq         <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= ADDR;
            arvalid_r <= 1'b1;
          end
        end
        ADDR: begin
          // arvalid is held until the handshake regardless of enable.
          if (m_axi.arready) begin
            state     <= DATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        DATA: begin
          if (m_axi.rvalid) begin
            state    <= WAIT;
            rready_r <= 1'b0;
            cnt      <= PERIOD_LOAD;
            if (rd_ok) begin
              sw_state <= rd_val;
              sw_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state     <= ADDR;
            arvalid_r <= 1'b1;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A fresh change beats a simultaneous acknowledge; only the new bits survive.
      if (change) begin
        irq         <= 1'b1;
        change_mask <= (irq_ack ? 2'b00 : change_mask) | rd_diff;
      end else if (irq_ack) begin
        irq         <= 1'b0;
        change_mask <= '0;
      end

      if (rd_bad) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_secure_switch_poller.sv
// Randomized bench for secure_switch_poller: a reactive AXI read slave plus a
// transaction-level reference model compared against every output each cycle.
module tb_secure_switch_poller;

  localparam int unsigned P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       irq_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] sw_state;
  logic       sw_valid;
  logic [1:0] change_mask;
  logic       irq;
  logic       bus_err;

  secure_switch_poller_if #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) bus ();

  secure_switch_poller #(
    .C_M_AXI_ADDR_WIDTH(4),
    .C_M_AXI_DATA_WIDTH(32),
    .SW_REG_ADDR(4'h0),
    .POLL_PERIOD(P)
  ) dut (
    .m_axi_aclk  (clk),
    .m_axi_areset(rst),
    .enable      (enable),
    .irq_ack     (irq_ack),
    .err_clr     (err_clr),
    .m_axi       (bus),
    .sw_state    (sw_state),
    .sw_valid    (sw_valid),
    .change_mask (change_mask),
    .irq         (irq),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: expected bus phase and register outputs after the last edge.
  bit       m_arv;
  bit       m_rr;
  int       m_wait;
  logic [1:0] m_sw;
  bit       m_valid;
  logic [1:0] m_mask;
  bit       m_irq;
  bit       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_arv   = 1'b0;
    m_rr    = 1'b0;
    m_wait  = 0;
    m_sw    = 2'b00;
    m_valid = 1'b0;
    m_mask  = 2'b00;
    m_irq   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    check("arvalid",     32'(bus.arvalid), 32'(m_arv));
    check("rready",      32'(bus.rready),  32'(m_rr));
    check("sw_state",    32'(sw_state),    32'(m_sw));
    check("sw_valid",    32'(sw_valid),    32'(m_valid));
    check("change_mask", 32'(change_mask), 32'(m_mask));
    check("irq",         32'(irq),         32'(m_irq));
    check("bus_err",     32'(bus_err),     32'(m_err));
    check("araddr",      32'(bus.araddr),  32'h0);
    check("arprot",      32'(bus.arprot),  32'h0);
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic predict();
    logic [1:0] nw;
    logic [1:0] d;
    bit chg;
    bit bad;
    chg = 1'b0;
    bad = 1'b0;
    d   = 2'b00;
    if (m_arv) begin
      if (bus.arready) begin
        m_arv = 1'b0;
        m_rr  = 1'b1;
      end
    end else if (m_rr) begin
      if (bus.rvalid) begin
        m_rr   = 1'b0;
        m_wait = int'(P);
        if (bus.rresp == 2'b00) begin
          nw = bus.rdata[1:0];
          if (m_valid && nw != m_sw) begin
            chg = 1'b1;
            d   = nw ^ m_sw;
          end
          m_sw    = nw;
          m_valid = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
    end else if (m_wait > 0) begin
      if (!enable) begin
        m_wait = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) m_arv = 1'b1;
      end
    end else if (enable) begin
      m_arv = 1'b1;
    end

    if (chg) begin
      m_mask = (irq_ack ? 2'b00 : m_mask) | d;
      m_irq  = 1'b1;
    end else if (irq_ack) begin
      m_mask = 2'b00;
      m_irq  = 1'b0;
    end

    if (bad) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  // One clock: compare at the falling edge, drive fresh inputs, predict, move on.
  task automatic step();
    check_outputs();
    if (enable) enable = ($urandom_range(99) >= 2);
    else        enable = ($urandom_range(99) < 10);
    bus.arready = ($urandom_range(99) < 40);
    bus.rvalid  = m_rr && ($urandom_range(99) < 40);
    bus.rdata   = $urandom;
    bus.rresp   = ($urandom_range(99) < 75) ? 2'b00 : 2'($urandom_range(3, 1));
    irq_ack     = bus.rvalid ? ($urandom_range(99) < 30) : ($urandom_range(99) < 8);
    err_clr     = ($urandom_range(99) < 10);
    predict();
    @(negedge clk);
  endtask

  task automatic reset_mid_data();
    int guard;
    guard = 0;
    while (!m_rr && guard < 200) begin
      step();
      guard++;
    end
    check("reach_data_rready", 32'(bus.rready), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    enable      = 1'b1;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    irq_ack     = 1'b0;
    err_clr     = 1'b0;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst    = 1'b0;
    enable = 1'b1;
    repeat (1500) step();
    reset_mid_data();
    repeat (1500) step();
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/secure_switch_poller.md
# secure_switch_poller

Autonomous AXI4-Lite read master that periodically polls the secure switch register (offset 0x00, bits [1:0] = switch state). It keeps a shadow copy of the switches and raises a level interrupt toward the secure-world interrupt controller when the state changes, so OP-TEE does not have to busy-poll the bus. It sits in the PL between a secure AXI interconnect master port and the switch peripheral. It issues secure data reads only.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4, width of m_axi_araddr
- C_M_AXI_DATA_WIDTH, 32, width of m_axi_rdata
- SW_REG_ADDR, 0, address driven on every read
- POLL_PERIOD, 100000, idle cycles between the end of one read and the start of the next; legal range 1..2^24-1

Ports:
- m_axi_aclk  in  1  sole clock
- m_axi_areset  in  1  reset, asynchronous, active-high
- enable  in  1  polling enable
- irq_ack  in  1  single-cycle pulse; clears irq and change_mask
- err_clr  in  1  single-cycle pulse; clears bus_err
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address, constant SW_REG_ADDR
- m_axi_arprot  out  3  constant 3'b000 (unprivileged, secure, data)
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  C_M_AXI_DATA_WIDTH  read data; only [1:0] used
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- sw_state  out  2  last successfully read switch value
- sw_valid  out  1  sw_state holds at least one good read
- change_mask  out  2  accumulated bits that toggled since last irq_ack
- irq  out  1  level interrupt, change pending
- bus_err  out  1  sticky, a read returned rresp != OKAY

Write channels are not present. The interconnect ties them off.

## Operation
- States: IDLE, ADDR, DATA, WAIT.
- IDLE: arvalid=0, rready=0. If enable=1, go to ADDR.
- ADDR: arvalid=1, rready=0. On arvalid&&arready, go to DATA. arvalid is never withdrawn before the handshake, whatever enable does.
- DATA: rready=1, arvalid=0. On rvalid, go to WAIT and load the period counter with POLL_PERIOD-1.
  - If rresp==2'b00:
    - new = rdata[1:0]; sw_state<=new; sw_valid<=1.
    - If sw_valid was already 1 and new!=sw_state: change_mask |= new^sw_state, irq<=1.
  - If rresp!=2'b00: sw_state, sw_valid and change_mask are unchanged; bus_err<=1.
- WAIT: the counter decrements each cycle.
  - If enable=0, go to IDLE immediately.
  - Else, when the counter is 0, go to ADDR.
- If enable drops during ADDR or DATA, the transaction completes normally, then WAIT sees enable=0 and goes to IDLE.
- sw_valid is not cleared by disable. A change that happens while disabled raises irq on the first read after re-enable. The first good read after reset never raises irq.
- irq_ack clears irq and change_mask.
  - If a change is detected in the same cycle as irq_ack: set wins. irq stays 1 and change_mask = new^sw_state (new bits only).
- err_clr clears bus_err. If it coincides with a new error, set wins.
- rdata bits above [1:0] are ignored.

## Timing
- Reset values (asynchronous assert): state=IDLE, counter=0, arvalid=0, rready=0, araddr=SW_REG_ADDR, arprot=0, sw_state=0, sw_valid=0, change_mask=0, irq=0, bus_err=0.
- All outputs are registered; no combinational path from inputs to outputs.
- arvalid rises the cycle after enable is sampled high in IDLE.
- rready rises the cycle after the AR handshake and falls the cycle after the R handshake.
- Outputs update the cycle after the R handshake: sw_state, sw_valid, change_mask, irq, bus_err.
- Exactly POLL_PERIOD cycles in WAIT; arvalid rises on the cycle after the last WAIT cycle.
- Poll cycle length with zero-wait slave (arready=1 in the first ADDR cycle, rvalid=1 in the first DATA cycle) is POLL_PERIOD+2 cycles.
- Reset asserted mid-transaction: all outputs return to reset values at once. The interconnect is reset on the same reset.
- At most one outstanding read; no address pipelining.

## Test plan
- Reset, POLL_PERIOD=4, enable=1, zero-wait slave returning 2'b01 -> arvalid high 1 cycle after enable; sw_state=01 and sw_valid=1; irq stays 0; arvalid rises every 6 cycles.
- Slave returns 01 then 11 -> irq=1 and change_mask=10 one cycle after the second R handshake; irq_ack pulse -> irq=0, change_mask=00.
- Slave arready held low 10 cycles while enable drops during ADDR -> arvalid stays high until the handshake, the read completes, FSM reaches IDLE, arvalid stays 0 afterwards.
- rresp=2'b10 with rdata=3 after good read of 00 -> sw_state stays 00, irq=0, bus_err=1; err_clr -> bus_err=0.
- Change detected in the same cycle as irq_ack (00->01 pending, then 01->00 with ack) -> irq remains 1, change_mask=01.
- Assert m_axi_areset while in DATA with rready=1 -> rready, arvalid, irq, sw_valid all 0 immediately; after release with enable=1, the first read does not raise irq.
